shreg_sequencer: RTL and testbench

//  Command-driven controller for a 4-bit 74194-style universal shift register.

---
 rtl/shreg_sequencer.sv | 129 ++++++++++++
 tb/tb_shreg_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shreg_sequencer.sv
// Command sequencer for a 4-bit 74194-style universal shift register, with a shadow copy.
// Latency: LOAD 3 cycles accept-to-accept, shift of N takes N+2, count 0 takes 2.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are not queued.
module shreg_sequencer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             CLR,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [3:0]       cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_fill,
   output logic             S1,
   output logic             S0,
   output logic             A,
   output logic             B,
   output logic             C,
   output logic             D,
   output logic             SR_IN,
   output logic             SL_IN,
   output logic [3:0]       q_shadow,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [1:0] OP_LOAD = 2'd0;
   localparam logic [1:0] OP_SHR  = 2'd1;
   localparam logic [1:0] OP_ROTL = 2'd3;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state_q;
   logic [1:0]       mode_q;
   logic [1:0]       op_q;
   logic [3:0]       data_q;
   logic             fill_q;
   logic [CNT_W-1:0] rem_q;
   logic [3:0]       q_q;
   logic [3:0]       q_d;
   logic             sl_in;

   // Rotate feeds QA back into QD; plain shifts feed the latched fill bit.
   assign sl_in = (op_q == OP_ROTL) ? q_q[3] : fill_q;

   // Next shadow value: what the register does on this edge given the driven mode.
   always_comb begin
      q_d = q_q;
      case (mode_q)
         MODE_LOAD: q_d = data_q;
         MODE_SHR:  q_d = {fill_q, q_q[3:1]};
         MODE_SHL:  q_d = {q_q[2:0], sl_in};
         default:   q_d = q_q;
      endcase
   end

   // Control FSM: latch the command on accept, drive the mode for exactly rem edges, then pulse done.
   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         state_q <= IDLE;
         mode_q  <= MODE_HOLD;
         op_q    <= OP_LOAD;
         data_q  <= 4'b0000;
         fill_q  <= 1'b0;
         rem_q   <= '0;
         q_q     <= 4'b0000;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  op_q   <= cmd_op;
                  fill_q <= cmd_fill;
                  if (cmd_op == OP_LOAD) begin
                     mode_q  <= MODE_LOAD;
                     data_q  <= cmd_data;
                     rem_q   <= ONE;
                     state_q <= RUN;
                  end else if (cmd_count == '0) begin
                     // Zero-length shift: no register edge at all, straight to completion.
                     rem_q   <= '0;
                     state_q <= DONE;
                  end else begin
                     mode_q  <= (cmd_op == OP_SHR) ? MODE_SHR : MODE_SHL;
                     rem_q   <= cmd_count;
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               q_q   <= q_d;
               rem_q <= rem_q - ONE;
               if (rem_q == ONE) begin
                  mode_q  <= MODE_HOLD;
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               mode_q  <= MODE_HOLD;
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign S1        = mode_q[1];
   assign S0        = mode_q[0];
   assign A         = data_q[3];
   assign B         = data_q[2];
   assign C         = data_q[1];
   assign D         = data_q[0];
   assign SR_IN     = fill_q;
   assign SL_IN     = sl_in;
   assign q_shadow  = q_q;

endmodule

// File: tb/tb_shreg_sequencer.sv
// Directed bench for shreg_sequencer with an independent 74194 datapath model and an expected-state queue.
// Latency checked per command: done cycle, mode duration, ready recovery.
// Backpressure checked by holding cmd_valid across a busy command.
module tb_shreg_sequencer;

   logic       clk = 1'b0;
   logic       CLR = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'd0;
   logic [3:0] cmd_data = 4'd0;
   logic [3:0] cmd_count = 4'd0;
   logic       cmd_fill = 1'b0;
   logic       S1, S0, A, B, C, D, SR_IN, SL_IN;
   logic [3:0] q_shadow;
   logic       busy, done;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] exp_q[$];
   logic [3:0] tb_q = 4'b0000;
   logic [3:0] reg_q;
   logic [1:0] mode_pre;
   logic [1:0] mode_seen;
   int         mode_cnt;
   int         done_cnt;

   always #5 clk = ~clk;

   shreg_sequencer #(.CNT_W(4)) dut (
      .clk(clk), .CLR(CLR),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
      .S1(S1), .S0(S0), .A(A), .B(B), .C(C), .D(D),
      .SR_IN(SR_IN), .SL_IN(SL_IN), .q_shadow(q_shadow),
      .busy(busy), .done(done)
   );

   // Behavioural 74194 driven only by the controller's register-side outputs.
   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) reg_q <= 4'b0000;
      else begin
         case ({S1, S0})
            2'b11:   reg_q <= {A, B, C, D};
            2'b01:   reg_q <= {SR_IN, reg_q[3:1]};
            2'b10:   reg_q <= {reg_q[2:0], SL_IN};
            default: reg_q <= reg_q;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: note the mode driven during the cycle, then check the edge's result against the queue.
   task automatic tick();
      logic [3:0] e;
      mode_pre = {S1, S0};
      @(posedge clk);
      #1;
      if (mode_pre != 2'b00) begin
         mode_cnt++;
         mode_seen = mode_pre;
         if (exp_q.size() == 0) begin
            chk("unexpected_edge", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("q_shadow", {28'd0, q_shadow}, {28'd0, e});
            chk("register", {28'd0, reg_q}, {28'd0, e});
         end
      end
      if (done) done_cnt++;
   endtask

   task automatic start_cmd(input logic [1:0] op, input logic [3:0] data,
                            input logic [3:0] count, input logic fill);
      int w;
      w = 0;
      while (!cmd_ready && w < 50) begin
         tick();
         w++;
      end
      chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
      cmd_op = op; cmd_data = data; cmd_count = count; cmd_fill = fill;
      cmd_valid = 1'b1;
      if (op == 2'd0) begin
         tb_q = data;
         exp_q.push_back(tb_q);
      end else begin
         for (int i = 0; i < int'(count); i++) begin
            case (op)
               2'd1:    tb_q = {fill, tb_q[3:1]};
               2'd2:    tb_q = {tb_q[2:0], fill};
               default: tb_q = {tb_q[2:0], tb_q[3]};
            endcase
            exp_q.push_back(tb_q);
         end
      end
      mode_cnt = 0;
      done_cnt = 0;
      tick();
      cmd_valid = 1'b0;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      chk("ready_low_busy", {31'd0, cmd_ready}, 32'd0);
   endtask

   task automatic finish_cmd(input logic [1:0] op, input logic [3:0] count);
      int k, exp_done, exp_modes;
      logic [1:0] exp_mode;
      exp_done  = (op == 2'd0) ? 2 : (count == 0) ? 1 : int'(count) + 1;
      exp_modes = (op == 2'd0) ? 1 : int'(count);
      exp_mode  = (op == 2'd0) ? 2'b11 : (op == 2'd1) ? 2'b01 : 2'b10;
      k = 0;
      while (!done && k < 40) begin
         tick();
         k++;
      end
      chk("done_latency", 32'(k + 1), 32'(exp_done));
      chk("mode_cycles", 32'(mode_cnt), 32'(exp_modes));
      if (exp_modes > 0) chk("mode_value", {30'd0, mode_seen}, {30'd0, exp_mode});
      tick();
      chk("done_width", {31'd0, done}, 32'd0);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("ready_after_done", {31'd0, cmd_ready}, 32'd1);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      chk("shadow_final", {28'd0, q_shadow}, {28'd0, tb_q});
   endtask

   initial begin
      // Power-on reset values.
      #2 CLR = 1'b0;
      #1;
      chk("rst_mode", {30'd0, S1, S0}, 32'd0);
      chk("rst_abcd", {28'd0, A, B, C, D}, 32'd0);
      chk("rst_serial", {30'd0, SR_IN, SL_IN}, 32'd0);
      chk("rst_shadow", {28'd0, q_shadow}, 32'd0);
      chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3 CLR = 1'b1;
      tick();
      chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

      // Reset in the middle of SHL 8 fill 1, after the third shift.
      start_cmd(2'd2, 4'd0, 4'd8, 1'b1);
      tick(); tick(); tick();
      chk("mid_shadow", {28'd0, q_shadow}, 32'h7);
      #2 CLR = 1'b0;
      #1;
      chk("midrst_mode", {30'd0, S1, S0}, 32'd0);
      chk("midrst_shadow", {28'd0, q_shadow}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      exp_q.delete();
      tb_q = 4'b0000;
      @(posedge clk);
      #3 CLR = 1'b1;
      tick();
      chk("ready_after_midrst", {31'd0, cmd_ready}, 32'd1);

      // LOAD, then SHL 3 fill 1.
      start_cmd(2'd0, 4'b0110, 4'd5, 1'b0);
      finish_cmd(2'd0, 4'd5);
      start_cmd(2'd2, 4'd0, 4'd3, 1'b1);
      finish_cmd(2'd2, 4'd3);

      // Rotate a single one all the way round.
      start_cmd(2'd0, 4'b1000, 4'd0, 1'b0);
      finish_cmd(2'd0, 4'd0);
      start_cmd(2'd3, 4'd0, 4'd4, 1'b1);
      finish_cmd(2'd3, 4'd4);

      // SHR 2 fill 0 while a LOAD 1010 is held pending across the busy window.
      start_cmd(2'd0, 4'b1111, 4'd0, 1'b0);
      finish_cmd(2'd0, 4'd0);
      start_cmd(2'd1, 4'd0, 4'd2, 1'b0);
      cmd_op = 2'd0; cmd_data = 4'b1010; cmd_valid = 1'b1;
      finish_cmd(2'd1, 4'd2);
      start_cmd(2'd0, 4'b1010, 4'd0, 1'b0);
      finish_cmd(2'd0, 4'd0);

      // Zero-count shift leaves everything alone.
      start_cmd(2'd2, 4'd0, 4'd0, 1'b1);
      finish_cmd(2'd2, 4'd0);

      // Maximum count: SHR 15 fill 1.
      start_cmd(2'd1, 4'd0, 4'd15, 1'b1);
      finish_cmd(2'd1, 4'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
